// File: rtl/pc_fetch_unit.sv
// Fetch-stage front end: owns the program counter, issues addresses to a
// synchronous instruction ROM with one cycle of read latency, and presents
// each fetched word with its PC to decode over a valid/ready handshake.
// Redirects squash both the presented word and the in-flight read.
// Back-pressure never drops or duplicates a word: while the output is held,
// the in-flight address is re-issued so the ROM keeps returning the same word.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [ADDR_W-1:0]  fetch_pc,
    output logic [INSTR_W-1:0] fetch_instr
);

    // Increment constant; the add wraps modulo 2^ADDR_W with no flag.
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Architectural state
    logic [ADDR_W-1:0]  pc_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_pc_r;
    logic               out_valid_r;
    logic [ADDR_W-1:0]  out_pc_r;
    logic [INSTR_W-1:0] out_instr_r;

    // Next-state values
    logic [ADDR_W-1:0]  pc_s;
    logic               inflight_s;
    logic [ADDR_W-1:0]  inflight_pc_s;
    logic               out_valid_s;
    logic [ADDR_W-1:0]  out_pc_s;
    logic [INSTR_W-1:0] out_instr_s;
    logic [ADDR_W-1:0]  addr_s;
    logic               advance_s;

    assign advance_s = (~out_valid_r) | fetch_ready;

    // Next-state and ROM address selection: redirect, then advance, then hold.
    always_comb begin
        pc_s          = pc_r;
        inflight_s    = inflight_r;
        inflight_pc_s = inflight_pc_r;
        out_valid_s   = out_valid_r;
        out_pc_s      = out_pc_r;
        out_instr_s   = out_instr_r;
        addr_s        = inflight_pc_r;

        if (redirect_valid) begin
            // Squash output and in-flight read; restart at the target.
            addr_s        = redirect_target;
            inflight_s    = 1'b1;
            inflight_pc_s = redirect_target;
            pc_s          = redirect_target + PC_ONE;
            out_valid_s   = 1'b0;
        end else if (advance_s) begin
            // Move the returning ROM word to the output and issue the next PC.
            addr_s        = pc_r;
            out_valid_s   = inflight_r;
            if (inflight_r) begin
                out_pc_s    = inflight_pc_r;
                out_instr_s = imem_rdata;
            end else begin
                // Nothing returning: keep last pc/instr on the idle output.
                out_pc_s    = out_pc_r;
                out_instr_s = out_instr_r;
            end
            inflight_s    = 1'b1;
            inflight_pc_s = pc_r;
            pc_s          = pc_r + PC_ONE;
        end else begin
            // Held by decode: re-read the in-flight word so it returns again.
            addr_s        = inflight_pc_r;
        end
    end

    // ROM address is forced to the reset PC while reset is asserted.
    assign imem_addr = reset_n ? addr_s : RESET_PC;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {ADDR_W{1'b0}};
            out_valid_r   <= 1'b0;
            out_pc_r      <= {ADDR_W{1'b0}};
            out_instr_r   <= {INSTR_W{1'b0}};
        end else begin
            pc_r          <= pc_s;
            inflight_r    <= inflight_s;
            inflight_pc_r <= inflight_pc_s;
            out_valid_r   <= out_valid_s;
            out_pc_r      <= out_pc_s;
            out_instr_r   <= out_instr_s;
        end
    end

    assign fetch_valid = out_valid_r;
    assign fetch_pc    = out_pc_r;
    assign fetch_instr = out_instr_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: a directed vector table for the documented
// scenarios, then randomized redirect/back-pressure/reset traffic checked
// against a stream-level reference model (gap countdown + current PC).
module tb_pc_fetch_unit;

    localparam int          ADDR_W   = 12;
    localparam int          INSTR_W  = 32;
    localparam logic [11:0] RESET_PC = 12'h000;

    logic               clock;
    logic               reset_n;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               fetch_valid;
    logic               fetch_ready;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fetch_instr;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [11:0] a);
        return 32'hA000_0000 + {20'h00000, a};
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clock) imem_rdata <= rom_word(imem_addr);

    // Reference model: edges left before output becomes valid, and stream PC.
    bit          m_valid;
    int          m_wait;
    logic [11:0] m_stream;
    logic [11:0] m_pc;
    logic [31:0] m_instr;

    task automatic model_reset();
        m_valid  = 1'b0;
        m_wait   = 2;
        m_stream = RESET_PC;
        m_pc     = 12'h000;
        m_instr  = 32'h0000_0000;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    // Entered and left at a falling edge.
    task automatic cycle(input logic rv, input logic [11:0] rt, input logic rdy,
                         input bit tab, input logic tv, input logic [11:0] tpc,
                         input logic [31:0] tinstr);
        logic [11:0] ea;
        redirect_valid  = rv;
        redirect_target = rt;
        fetch_ready     = rdy;
        #1;
        if (rv)               ea = rt;
        else if (m_wait == 2) ea = m_stream;
        else if (m_wait == 1) ea = m_stream + 12'd1;
        else if (rdy)         ea = m_pc + 12'd2;
        else                  ea = m_pc + 12'd1;
        chk("imem_addr",   {20'h0, imem_addr},   {20'h0, ea});
        chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, m_valid});
        chk("fetch_pc",    {20'h0, fetch_pc},    {20'h0, m_pc});
        chk("fetch_instr", fetch_instr,          m_instr);
        if (tab) begin
            chk("tab_valid", {31'h0, fetch_valid}, {31'h0, tv});
            chk("tab_pc",    {20'h0, fetch_pc},    {20'h0, tpc});
            chk("tab_instr", fetch_instr,          tinstr);
        end
        @(posedge clock);
        if (rv) begin
            m_valid  = 1'b0;
            m_wait   = 1;
            m_stream = rt;
        end else if (m_wait == 2) begin
            m_wait = 1;
        end else if (m_wait == 1) begin
            m_wait  = 0;
            m_valid = 1'b1;
            m_pc    = m_stream;
            m_instr = rom_word(m_stream);
        end else if (rdy) begin
            m_pc    = m_pc + 12'd1;
            m_instr = rom_word(m_pc);
        end else begin
            m_pc = m_pc;
        end
        @(negedge clock);
    endtask

    // Asynchronous reset pulse between edges; entered and left at a falling edge.
    task automatic do_reset();
        #2;
        redirect_valid  = 1'b1;
        redirect_target = 12'h555;
        reset_n         = 1'b0;
        #1;
        chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_addr",  {20'h0, imem_addr},   {20'h0, RESET_PC});
        chk("rst_pc",    {20'h0, fetch_pc},    32'h0);
        chk("rst_instr", fetch_instr,          32'h0);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_hold_valid", {31'h0, fetch_valid}, 32'h0);
        chk("rst_hold_addr",  {20'h0, imem_addr},   {20'h0, RESET_PC});
        @(negedge clock);
        redirect_valid = 1'b0;
        reset_n        = 1'b1;
    endtask

    typedef struct {
        logic        rv;
        logic [11:0] rt;
        logic        rdy;
        logic        ev;
        logic [11:0] epc;
        logic [31:0] einstr;
    } vec_t;

    vec_t tab[$];

    task automatic add(input logic rv, input logic [11:0] rt, input logic rdy,
                       input logic ev, input logic [11:0] epc, input bit zero_instr);
        vec_t v;
        v.rv = rv; v.rt = rt; v.rdy = rdy; v.ev = ev; v.epc = epc;
        v.einstr = zero_instr ? 32'h0000_0000 : rom_word(epc);
        tab.push_back(v);
    endtask

    initial begin
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 12'h000;
        fetch_ready     = 1'b0;
        model_reset();

        // Reset release and streaming from RESET_PC.
        add(0, 12'h000, 1, 0, 12'h000, 1);
        add(0, 12'h000, 1, 0, 12'h000, 1);
        add(0, 12'h000, 1, 1, 12'h000, 0);
        add(0, 12'h000, 1, 1, 12'h001, 0);
        add(0, 12'h000, 1, 1, 12'h002, 0);
        add(0, 12'h000, 1, 1, 12'h003, 0);
        add(0, 12'h000, 1, 1, 12'h004, 0);
        // Three-cycle stall at pc 5.
        add(0, 12'h000, 0, 1, 12'h005, 0);
        add(0, 12'h000, 0, 1, 12'h005, 0);
        add(0, 12'h000, 0, 1, 12'h005, 0);
        add(0, 12'h000, 1, 1, 12'h005, 0);
        add(0, 12'h000, 1, 1, 12'h006, 0);
        // Redirect to 0x100 while pc 7 is presented.
        add(1, 12'h100, 1, 1, 12'h007, 0);
        add(0, 12'h000, 1, 0, 12'h007, 0);
        add(0, 12'h000, 1, 1, 12'h100, 0);
        add(0, 12'h000, 1, 1, 12'h101, 0);
        // Redirect to 8, then redirect during HOLD at pc 9.
        add(1, 12'h008, 1, 1, 12'h102, 0);
        add(0, 12'h000, 1, 0, 12'h102, 0);
        add(0, 12'h000, 1, 1, 12'h008, 0);
        add(0, 12'h000, 0, 1, 12'h009, 0);
        add(1, 12'h020, 0, 1, 12'h009, 0);
        add(0, 12'h000, 1, 0, 12'h009, 0);
        add(0, 12'h000, 1, 1, 12'h020, 0);
        // Redirect near the top of the address space: wrap-around.
        add(1, 12'hFFE, 1, 1, 12'h021, 0);
        add(0, 12'h000, 1, 0, 12'h021, 0);
        add(0, 12'h000, 1, 1, 12'hFFE, 0);
        add(0, 12'h000, 1, 1, 12'hFFF, 0);
        add(0, 12'h000, 1, 1, 12'h000, 0);
        add(0, 12'h000, 1, 1, 12'h001, 0);
        // Move to 0x040 for the mid-stream reset.
        add(1, 12'h040, 1, 1, 12'h002, 0);
        add(0, 12'h000, 1, 0, 12'h002, 0);
        add(0, 12'h000, 1, 1, 12'h040, 0);

        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        chk("init_valid", {31'h0, fetch_valid}, 32'h0);
        chk("init_addr",  {20'h0, imem_addr},   {20'h0, RESET_PC});
        chk("init_pc",    {20'h0, fetch_pc},    32'h0);
        chk("init_instr", fetch_instr,          32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        foreach (tab[i])
            cycle(tab[i].rv, tab[i].rt, tab[i].rdy, 1'b1,
                  tab[i].ev, tab[i].epc, tab[i].einstr);

        // Now presenting pc 0x041: pulse reset mid-stream.
        #1;
        chk("pre_rst_valid", {31'h0, fetch_valid}, 32'h1);
        chk("pre_rst_pc",    {20'h0, fetch_pc},    32'h41);
        do_reset();
        cycle(0, 12'h000, 1, 1'b1, 1'b0, 12'h000, 32'h0);
        cycle(0, 12'h000, 1, 1'b1, 1'b0, 12'h000, 32'h0);
        cycle(0, 12'h000, 1, 1'b1, 1'b1, RESET_PC, rom_word(RESET_PC));
        cycle(0, 12'h000, 1, 1'b1, 1'b1, RESET_PC + 12'd1, rom_word(RESET_PC + 12'd1));

        // Randomized redirects, back-pressure and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic        rv;
            logic [11:0] rt;
            logic        rdy;
            rv  = ($urandom_range(0, 9) == 0);
            rt  = ($urandom_range(0, 3) == 0) ? (12'hFF0 | 12'($urandom_range(0, 15)))
                                              : 12'($urandom_range(0, 4095));
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 299) == 0) do_reset();
            cycle(rv, rt, rdy, 1'b0, 1'b0, 12'h000, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
